// File: rtl/key_mode_select.sv
// Two active-low push-buttons -> synchronised, debounced, press-toggled 2-bit mode select.
// Optional build macro LONG_PRESS_CLEAR_EN adds a both-keys long-hold clear of the select.
module key_mode_select #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key0,
    input  logic       key1,
    output logic [1:0] select,
    output logic       press0,
    output logic       press1,
    output logic       clear_pulse
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES - 1)) begin : g_bad_param
        $error("key_mode_select: invalid DEBOUNCE_CYCLES/CNT_W/LONG_CYCLES");
    end

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       keys;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       stable;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       accept;
    logic [1:0]       fall;
    logic             clear_fire;

    assign keys = {key1, key0};

    always_comb begin
        accept = '0;
        fall   = '0;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync_p1[i] != stable[i]) && (cnt[i] == DB_MAX);
            fall[i]   = accept[i] && !sync_p1[i];
        end
    end

    // Stage p0/p1: two-flop synchroniser, then per-key debounce counter on the synced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
            stable  <= 2'b11;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
        end else begin
            sync_p0 <= keys;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync_p1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef LONG_PRESS_CLEAR_EN
    localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;
    logic              both_held;

    assign both_held  = (stable == 2'b00);
    assign clear_fire = both_held && (hold_cnt == HOLD_FIRE);

    // Counter parks one past the fire value so a continued hold cannot fire again.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt    <= '0;
            clear_pulse <= 1'b0;
        end else begin
            clear_pulse <= clear_fire;
            if (!both_held) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign clear_fire  = 1'b0;
    assign clear_pulse = 1'b0;
`endif

    // Stage p2: registered select and press pulses; only accepted presses toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            select <= 2'b00;
            press0 <= 1'b0;
            press1 <= 1'b0;
        end else begin
            press0 <= fall[0];
            press1 <= fall[1];
            if (clear_fire) begin
                select <= 2'b00;
            end else begin
                select <= select ^ fall;
            end
        end
    end

endmodule
